// File: rtl/io_debounce_pkg.sv
// Shared definitions for the io_debounce input conditioning block.
package io_debounce_pkg;

  // Per-bit debounce FSM states
  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_COUNT  = 1'b1
  } db_state_e;

  // Board build defaults, shared so system_io and memory_map agree on width
  localparam int DEF_WIDTH           = 4;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 50000;

endpackage

// File: rtl/io_debounce_bit.sv
// One input bit: synchroniser chain, debounce FSM with its stability
// counter, and registered rise/fall pulse outputs.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_STABLE | synchronised input agrees with the debounced level
// ST_COUNT  | input disagrees; counting consecutive disagreeing samples
module io_debounce_bit
  import io_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic settling
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  db_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign sync = sync_q[SYNC_STAGES-1];

  // Synchroniser chain; raw enters at bit 0, last stage feeds the FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  // State, counter, debounced level and pulse registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next-state logic; pulses default low so they last exactly one cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (sync != clean_q) begin
          state_d = ST_COUNT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      ST_COUNT: begin
        if (sync == clean_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          clean_d = sync;
          rise_d  = sync;
          fall_d  = ~sync;
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign clean    = clean_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign settling = (state_q == ST_COUNT);

endmodule

// File: rtl/io_debounce.sv
// Input conditioning upstream of system_io io_in: one independent
// synchronise-and-debounce slice per input bit. Wiring only.
module io_debounce
  import io_debounce_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] io_clean,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] settling
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    io_debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk      (clk),
      .reset    (reset),
      .raw      (raw_in[i]),
      .clean    (io_clean[i]),
      .rise     (rise_pulse[i]),
      .fall     (fall_pulse[i]),
      .settling (settling[i])
    );
  end

endmodule

// File: tb/tb_io_debounce.sv
// Bench for io_debounce: directed scenarios plus random input activity,
// compared every cycle against a sample-window reference model.
module tb_io_debounce;

  localparam int WIDTH = 4;
  localparam int SYNC  = 2;
  localparam int DEB   = 4;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] io_clean;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;
  logic [WIDTH-1:0] settling;

  int errors = 0;
  int checks = 0;

  io_debounce #(
    .WIDTH           (WIDTH),
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .raw_in     (raw_in),
    .io_clean   (io_clean),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .settling   (settling)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: raw is delayed SYNC edges, then a level is accepted
  // once the last DEB delayed samples all disagree with the current level.
  logic [WIDTH-1:0] pipe [SYNC];
  logic [WIDTH-1:0] hist [DEB];
  logic [WIDTH-1:0] m_clean, m_rise, m_fall, m_settle, sync_now;
  logic             all_diff;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < SYNC; k++) pipe[k] = '0;
      for (int k = 0; k < DEB; k++)  hist[k] = '0;
      m_clean  = '0;
      m_rise   = '0;
      m_fall   = '0;
      m_settle = '0;
    end else begin
      sync_now = pipe[SYNC-1];
      for (int k = SYNC-1; k > 0; k--) pipe[k] = pipe[k-1];
      pipe[0] = raw_in;
      for (int k = DEB-1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = sync_now;
      m_rise = '0;
      m_fall = '0;
      for (int b = 0; b < WIDTH; b++) begin
        all_diff = 1'b1;
        for (int k = 0; k < DEB; k++)
          if (hist[k][b] == m_clean[b]) all_diff = 1'b0;
        if (all_diff) begin
          m_clean[b] = ~m_clean[b];
          if (m_clean[b]) m_rise[b] = 1'b1;
          else            m_fall[b] = 1'b1;
        end
        m_settle[b] = (sync_now[b] != m_clean[b]);
      end
    end
  end

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare outputs of the last edge against the model, then drive raw_in
  task automatic cycle(input logic [WIDTH-1:0] r);
    @(negedge clk);
    check("clean", io_clean, m_clean);
    check("rise", rise_pulse, m_rise);
    check("fall", fall_pulse, m_fall);
    check("settling", settling, m_settle);
    check("rise_and_fall", rise_pulse & fall_pulse, '0);
    raw_in = r;
  endtask

  logic [WIDTH-1:0] mask;

  initial begin
    reset  = 1'b0;
    raw_in = 4'hF;

    // Reset held with inputs high: everything stays clear
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_clean", io_clean, 4'h0);
      check("rst_rise", rise_pulse, 4'h0);
      check("rst_settle", settling, 4'h0);
    end
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cycle(4'hF);
      check("rel_clean", io_clean, (k >= 6) ? 4'hF : 4'h0);
      check("rel_rise", rise_pulse, (k == 6) ? 4'hF : 4'h0);
    end
    for (int k = 0; k < 10; k++) cycle(4'h0);

    // Clean step on bit 0
    cycle(4'h1);
    for (int k = 1; k <= 8; k++) begin
      cycle(4'h1);
      check("step_clean", io_clean, (k >= 6) ? 4'h1 : 4'h0);
      check("step_rise", rise_pulse, (k == 6) ? 4'h1 : 4'h0);
      check("step_settle", settling, (k >= 3 && k < 6) ? 4'h1 : 4'h0);
    end

    // Bounce on bit 1
    cycle(4'h3);
    cycle(4'h1);
    cycle(4'h3);
    cycle(4'h1);
    check("bounce_rise", rise_pulse, 4'h0);
    cycle(4'h3);
    for (int k = 1; k <= 8; k++) begin
      cycle(4'h3);
      check("bounce_clean", io_clean, (k >= 6) ? 4'h3 : 4'h1);
      check("bounce_rise", rise_pulse, (k == 6) ? 4'h2 : 4'h0);
    end

    // Glitch of three samples on bit 2
    cycle(4'h7);
    cycle(4'h7);
    cycle(4'h7);
    for (int k = 0; k < 10; k++) begin
      cycle(4'h3);
      check("glitch_clean", io_clean, 4'h3);
      check("glitch_pulse", rise_pulse | fall_pulse, 4'h0);
    end
    check("glitch_settle", settling, 4'h0);

    // Simultaneous changes on bits 0 and 2
    for (int k = 0; k < 10; k++) cycle(4'h0);
    cycle(4'h5);
    for (int k = 1; k <= 8; k++) begin
      cycle(4'h5);
      check("sim_clean", io_clean, (k >= 6) ? 4'h5 : 4'h0);
      check("sim_rise", rise_pulse, (k == 6) ? 4'h5 : 4'h0);
      check("sim_fall", fall_pulse, 4'h0);
    end
    cycle(4'h0);
    for (int k = 1; k <= 8; k++) begin
      cycle(4'h0);
      check("sim_fall", fall_pulse, (k == 6) ? 4'h5 : 4'h0);
      check("sim_rise", rise_pulse, 4'h0);
    end

    // Reset in the middle of a count on bit 3, with bit 0 already high
    for (int k = 0; k < 8; k++) cycle(4'h1);
    cycle(4'h9);
    for (int k = 1; k <= 3; k++) begin
      cycle(4'h9);
      check("mid_settle", settling, (k >= 3) ? 4'h8 : 4'h0);
    end
    #1 reset = 1'b0;
    #1;
    check("mid_rst_clean", io_clean, 4'h0);
    check("mid_rst_settle", settling, 4'h0);
    check("mid_rst_pulse", rise_pulse | fall_pulse, 4'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cycle(4'h9);
      check("redeb_clean", io_clean, (k >= 6) ? 4'h9 : 4'h0);
      check("redeb_rise", rise_pulse, (k == 6) ? 4'h9 : 4'h0);
    end

    // Random activity with quiet stretches and one asynchronous reset
    for (int i = 0; i < 1500; i++) begin
      mask = '0;
      if ((i % 200) >= 60)
        for (int b = 0; b < WIDTH; b++)
          if ($urandom_range(5) == 0) mask[b] = 1'b1;
      cycle(raw_in ^ mask);
      if (i == 700) begin
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end
    end
    for (int k = 0; k < 10; k++) cycle(raw_in);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
